// File: rtl/shift_seq_ctrl_pkg.sv
// Shared encodings for the shift sequencer and the universal shift register it drives.
package shift_seq_ctrl_pkg;

   localparam logic [1:0] S_HOLD = 2'd0;
   localparam logic [1:0] S_SHR  = 2'd1;
   localparam logic [1:0] S_SHL  = 2'd2;
   localparam logic [1:0] S_LOAD = 2'd3;

   localparam logic [1:0] F_ZERO  = 2'd0;
   localparam logic [1:0] F_ONE   = 2'd1;
   localparam logic [1:0] F_ROT   = 2'd2;
   localparam logic [1:0] F_ARITH = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_CAPT,
      ST_DONE
   } state_t;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Command/result handshake between a requesting datapath and the shift sequencer.
interface shift_seq_ctrl_if #(
   parameter int W  = 8,
   parameter int AW = $clog2(W) + 1
);
   logic          start;
   logic          dir;
   logic [1:0]    fill;
   logic [AW-1:0] amt;
   logic [W-1:0]  data_in;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;

   modport master (
      output start, dir, fill, amt, data_in,
      input  busy, done, result
   );

   modport slave (
      input  start, dir, fill, amt, data_in,
      output busy, done, result
   );
endinterface

// File: rtl/shift_reg.sv
// Four-mode universal shift register: hold, shift right, shift left, parallel load.
module shift_reg
   import shift_seq_ctrl_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic [1:0]   s,
   input  logic [W-1:0] din,
   input  logic         srsi,
   input  logic         slsi,
   output logic [W-1:0] dout
);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         dout <= '0;
      end else begin
         unique case (s)
            S_SHR:   dout <= {srsi, dout[W-1:1]};
            S_SHL:   dout <= {dout[W-2:0], slsi};
            S_LOAD:  dout <= din;
            default: dout <= dout;
         endcase
      end
   end

endmodule

// File: rtl/shift_unit.sv
// Integration wrapper: sequencer plus the shift register whose control pins it owns.
module shift_unit
   import shift_seq_ctrl_pkg::*;
#(
   parameter int W  = 8,
   parameter int AW = $clog2(W) + 1
) (
   input  logic             clk,
   input  logic             clr,
   shift_seq_ctrl_if.slave  cmd
);

   logic [1:0]   sh_s;
   logic [W-1:0] sh_din;
   logic [W-1:0] sh_dout;
   logic         sh_srsi;
   logic         sh_slsi;
   logic         clr_n;

   assign clr_n = ~clr;

   shift_seq_ctrl #(.W(W), .AW(AW)) u_ctrl (
      .clk     (clk),
      .clr     (clr),
      .cmd     (cmd),
      .sh_dout (sh_dout),
      .sh_s    (sh_s),
      .sh_din  (sh_din),
      .sh_srsi (sh_srsi),
      .sh_slsi (sh_slsi)
   );

   shift_reg #(.W(W)) u_sreg (
      .clk   (clk),
      .clr_n (clr_n),
      .s     (sh_s),
      .din   (sh_din),
      .srsi  (sh_srsi),
      .slsi  (sh_slsi),
      .dout  (sh_dout)
   );

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequences load / N single-bit shifts / capture on a universal shift register
// to perform one multi-bit shift or rotate per start/done handshake.
module shift_seq_ctrl
   import shift_seq_ctrl_pkg::*;
#(
   parameter int W  = 8,
   parameter int AW = $clog2(W) + 1
) (
   input  logic             clk,
   input  logic             clr,
   shift_seq_ctrl_if.slave  cmd,
   input  logic [W-1:0]     sh_dout,
   output logic [1:0]       sh_s,
   output logic [W-1:0]     sh_din,
   output logic             sh_srsi,
   output logic             sh_slsi
);

   localparam logic [AW-1:0] AMT_MAX = AW'(W);

   state_t        state, state_nxt;
   logic          dir_q;
   logic [1:0]    fill_q;
   logic [AW-1:0] amt_q;
   logic [AW-1:0] cnt;
   logic [W-1:0]  data_q;
   logic [W-1:0]  result_q;
   logic [AW-1:0] amt_eff;
   logic          accept;
   logic          busy_c;
   logic          done_c;

   assign amt_eff = (cmd.amt > AMT_MAX) ? AMT_MAX : cmd.amt;
   assign accept  = (state == ST_IDLE) && cmd.start;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state    <= ST_IDLE;
         dir_q    <= 1'b0;
         fill_q   <= F_ZERO;
         amt_q    <= '0;
         cnt      <= '0;
         result_q <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            dir_q  <= cmd.dir;
            fill_q <= cmd.fill;
            amt_q  <= amt_eff;
         end
         if (state == ST_LOAD) begin
            cnt <= amt_q;
         end else if (state == ST_SHIFT) begin
            cnt <= cnt - 1'b1;
         end
         if (state == ST_CAPT) begin
            result_q <= sh_dout;
         end
      end
   end

   // Operand is pure data; it is only observed in LOAD after being latched.
   always_ff @(posedge clk) begin
      if (accept) begin
         data_q <= cmd.data_in;
      end
   end

   always_comb begin
      state_nxt = state;
      sh_s      = S_HOLD;
      sh_din    = '0;
      busy_c    = 1'b0;
      done_c    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (cmd.start) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            sh_s      = S_LOAD;
            sh_din    = data_q;
            busy_c    = 1'b1;
            state_nxt = (amt_q == '0) ? ST_CAPT : ST_SHIFT;
         end
         ST_SHIFT: begin
            sh_s   = dir_q ? S_SHL : S_SHR;
            busy_c = 1'b1;
            if (cnt == AW'(1)) state_nxt = ST_CAPT;
         end
         ST_CAPT: begin
            busy_c    = 1'b1;
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done_c    = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Arithmetic fill only has meaning for right shifts; on a left shift it behaves as zero fill.
   always_comb begin
      sh_srsi = 1'b0;
      sh_slsi = 1'b0;
      if (!dir_q) begin
         unique case (fill_q)
            F_ONE:   sh_srsi = 1'b1;
            F_ROT:   sh_srsi = sh_dout[0];
            F_ARITH: sh_srsi = sh_dout[W-1];
            default: sh_srsi = 1'b0;
         endcase
      end else begin
         unique case (fill_q)
            F_ONE:   sh_slsi = 1'b1;
            F_ROT:   sh_slsi = sh_dout[W-1];
            default: sh_slsi = 1'b0;
         endcase
      end
   end

   assign cmd.busy   = busy_c;
   assign cmd.done   = done_c;
   assign cmd.result = result_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl driving a universal shift register (W=8).
module tb_shift_seq_ctrl;
   import shift_seq_ctrl_pkg::*;

   localparam int W  = 8;
   localparam int AW = 4;

   logic         clk = 1'b0;
   logic         clr;
   logic         clr_n;
   logic [1:0]   sh_s;
   logic [W-1:0] sh_din;
   logic [W-1:0] sh_dout;
   logic         sh_srsi;
   logic         sh_slsi;

   int errors = 0;
   int checks = 0;

   assign clr_n = ~clr;

   shift_seq_ctrl_if #(.W(W), .AW(AW)) cmd ();

   shift_seq_ctrl #(.W(W), .AW(AW)) dut (
      .clk     (clk),
      .clr     (clr),
      .cmd     (cmd.slave),
      .sh_dout (sh_dout),
      .sh_s    (sh_s),
      .sh_din  (sh_din),
      .sh_srsi (sh_srsi),
      .sh_slsi (sh_slsi)
   );

   shift_reg #(.W(W)) u_sreg (
      .clk   (clk),
      .clr_n (clr_n),
      .s     (sh_s),
      .din   (sh_din),
      .srsi  (sh_srsi),
      .slsi  (sh_slsi),
      .dout  (sh_dout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one command and follows it to done; inject>=0 pulses a stray start at that cycle.
   task automatic run_cmd(input string tag, input logic [7:0] d, input logic dr,
                          input logic [1:0] f, input logic [AW-1:0] a,
                          input logic [7:0] exp_res, input int inject);
      int amt_eff;
      int busy_cnt;
      int load_cnt;
      int shr_cnt;
      int shl_cnt;
      int overlap;
      int lat;
      bit seen;
      amt_eff  = (int'(a) > W) ? W : int'(a);
      busy_cnt = 0;
      load_cnt = 0;
      shr_cnt  = 0;
      shl_cnt  = 0;
      overlap  = 0;
      lat      = -1;
      seen     = 1'b0;
      cmd.data_in = d;
      cmd.dir     = dr;
      cmd.fill    = f;
      cmd.amt     = a;
      cmd.start   = 1'b1;
      tick();
      cmd.start   = 1'b0;
      cmd.data_in = ~d;
      for (int j = 0; j < 40 && !seen; j++) begin
         if (cmd.busy && cmd.done) overlap++;
         if (cmd.done) begin
            seen = 1'b1;
            lat  = j;
         end else begin
            if (cmd.busy) busy_cnt++;
            if (sh_s == S_LOAD) load_cnt++;
            if (sh_s == S_SHR) shr_cnt++;
            if (sh_s == S_SHL) shl_cnt++;
            if (j == inject) begin
               cmd.start   = 1'b1;
               cmd.data_in = 8'h11;
               cmd.dir     = ~dr;
               cmd.fill    = F_ONE;
               cmd.amt     = 4'd1;
            end else if (j == inject + 1) begin
               cmd.start = 1'b0;
            end
            tick();
         end
      end
      cmd.start = 1'b0;
      check({tag, "/done_seen"}, 32'(seen), 32'd1);
      check({tag, "/latency"}, 32'(lat), 32'(amt_eff + 2));
      check({tag, "/busy_cycles"}, 32'(busy_cnt), 32'(amt_eff + 2));
      check({tag, "/load_cycles"}, 32'(load_cnt), 32'd1);
      check({tag, "/shr_cycles"}, 32'(shr_cnt), dr ? 32'd0 : 32'(amt_eff));
      check({tag, "/shl_cycles"}, 32'(shl_cnt), dr ? 32'(amt_eff) : 32'd0);
      check({tag, "/busy_done_overlap"}, 32'(overlap), 32'd0);
      check({tag, "/result"}, 32'(cmd.result), 32'(exp_res));
      tick();
      check({tag, "/done_pulse_width"}, 32'(cmd.done), 32'd0);
      check({tag, "/idle_busy"}, 32'(cmd.busy), 32'd0);
      check({tag, "/result_held"}, 32'(cmd.result), 32'(exp_res));
   endtask

   initial begin
      int done_seen;
      cmd.start   = 1'b0;
      cmd.dir     = 1'b0;
      cmd.fill    = F_ZERO;
      cmd.amt     = '0;
      cmd.data_in = '0;
      clr = 1'b1;
      tick();
      tick();
      check("reset/busy", 32'(cmd.busy), 32'd0);
      check("reset/done", 32'(cmd.done), 32'd0);
      check("reset/result", 32'(cmd.result), 32'd0);
      check("reset/sh_s", 32'(sh_s), 32'(S_HOLD));
      check("reset/sh_din", 32'(sh_din), 32'd0);
      clr = 1'b0;
      tick();

      run_cmd("shr_zero3",   8'h0F, 1'b0, F_ZERO,  4'd3,  8'h01, -1);
      run_cmd("shl_one2",    8'h0D, 1'b1, F_ONE,   4'd2,  8'h37, -1);
      run_cmd("rotr4",       8'h8D, 1'b0, F_ROT,   4'd4,  8'hD8, -1);
      run_cmd("rotr12_clamp",8'hCD, 1'b0, F_ROT,   4'd12, 8'hCD, -1);
      run_cmd("ashr3",       8'h9D, 1'b0, F_ARITH, 4'd3,  8'hF3, -1);
      run_cmd("ashl3",       8'h9D, 1'b1, F_ARITH, 4'd3,  8'hE8, -1);
      run_cmd("amt0",        8'hA5, 1'b0, F_ZERO,  4'd0,  8'hA5, -1);
      run_cmd("ignore_start",8'h0F, 1'b0, F_ZERO,  4'd3,  8'h01, 1);

      // Abort in the middle of a shift sequence.
      cmd.data_in = 8'h3C;
      cmd.dir     = 1'b0;
      cmd.fill    = F_ZERO;
      cmd.amt     = 4'd5;
      cmd.start   = 1'b1;
      tick();
      cmd.start = 1'b0;
      tick();
      tick();
      check("abort/in_shift", 32'(sh_s), 32'(S_SHR));
      clr = 1'b1;
      #1;
      check("abort/busy", 32'(cmd.busy), 32'd0);
      check("abort/done", 32'(cmd.done), 32'd0);
      check("abort/result", 32'(cmd.result), 32'd0);
      check("abort/sh_s", 32'(sh_s), 32'(S_HOLD));
      done_seen = 0;
      for (int j = 0; j < 3; j++) begin
         tick();
         if (cmd.done) done_seen++;
      end
      clr = 1'b0;
      for (int j = 0; j < 8; j++) begin
         tick();
         if (cmd.done) done_seen++;
      end
      check("abort/no_done", 32'(done_seen), 32'd0);
      check("abort/idle", 32'(cmd.busy), 32'd0);

      run_cmd("post_abort",  8'hF0, 1'b0, F_ZERO,  4'd4,  8'h0F, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
